// File: rtl/al_accel_pkg.sv
// +--------------------------------------------------------------------------+
// | al_accel_pkg                                                             |
// | Shared widths, LUT word type and sign-extension helper for al_accel_lut. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package al_accel_pkg;

   localparam int DW        = 8;
   localparam int OW        = DW + 2;
   localparam int LUT_DEPTH = 8;

   typedef logic signed [OW-1:0] lut_word_t;

   function automatic lut_word_t sext_dw_to_ow(input logic [DW-1:0] a);
      return {{(OW-DW){a[DW-1]}}, a};
   endfunction

endpackage

`default_nettype wire

// File: rtl/al_accel_lut_sum.sv
// +--------------------------------------------------------------------------+
// | al_accel_lut_sum                                                         |
// | Combinational signed 3-input add: sum of +/-idi_i selected by sbits[i].  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module al_accel_lut_sum
   import al_accel_pkg::*;
(
   input  logic [DW-1:0] idi_0,
   input  logic [DW-1:0] idi_1,
   input  logic [DW-1:0] idi_2,
   input  logic [2:0]    sbits,
   output lut_word_t     sum
);

   lut_word_t w_t0;
   lut_word_t w_t1;
   lut_word_t w_t2;

   // Negation happens after widening, so -(-128) stays +128.
   always_comb begin
      w_t0 = sbits[0] ? -sext_dw_to_ow(idi_0) : sext_dw_to_ow(idi_0);
      w_t1 = sbits[1] ? -sext_dw_to_ow(idi_1) : sext_dw_to_ow(idi_1);
      w_t2 = sbits[2] ? -sext_dw_to_ow(idi_2) : sext_dw_to_ow(idi_2);
      sum  = w_t0 + w_t1 + w_t2;
   end

endmodule

`default_nettype wire

// File: rtl/al_accel_lut.sv
// +--------------------------------------------------------------------------+
// | al_accel_lut                                                             |
// | 3-lane sign-only dot-product LUT: load 8 precomputed sums, read by sign. |
// | Option: AL_ACCEL_LUT_SYM_EN stores 4 entries, negates for s2=1.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module al_accel_lut
   import al_accel_pkg::*;
(
   input  logic          clk,
   input  logic          resetn,
   input  logic          enb,
   input  logic          lut_ld_wrn,
   input  logic [DW-1:0] lut_idi_0,
   input  logic [DW-1:0] lut_idi_1,
   input  logic [DW-1:0] lut_idi_2,
   input  logic          lut_wdi_sbit_0,
   input  logic          lut_wdi_sbit_1,
   input  logic          lut_wdi_sbit_2,
   output logic [OW-1:0] lut_odo,
   output logic          lut_odo_vld,
   output logic          lut_rdy
);

`ifdef AL_ACCEL_LUT_SYM_EN
   localparam int c_STORE = LUT_DEPTH / 2;
`else
   localparam int c_STORE = LUT_DEPTH;
`endif

   lut_word_t  r_lut [c_STORE];
   lut_word_t  w_sum [c_STORE];
   lut_word_t  w_rd;
   lut_word_t  r_odo;
   logic       r_vld;
   logic       r_rdy;
   logic [2:0] w_idx;

   generate
      for (genvar k = 0; k < c_STORE; k++) begin : g_sum
         al_accel_lut_sum u_sum (
            .idi_0 (lut_idi_0),
            .idi_1 (lut_idi_1),
            .idi_2 (lut_idi_2),
            .sbits (3'(k)),
            .sum   (w_sum[k])
         );
      end
   endgenerate

   assign w_idx = {lut_wdi_sbit_2, lut_wdi_sbit_1, lut_wdi_sbit_0};

   // Upper half mirrors the lower half: entry[k] = -entry[~k].
   always_comb begin
      w_rd = '0;
`ifdef AL_ACCEL_LUT_SYM_EN
      if (w_idx[2])
         w_rd = -r_lut[~w_idx[1:0]];
      else
         w_rd = r_lut[w_idx[1:0]];
`else
      w_rd = r_lut[w_idx];
`endif
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < c_STORE; k++)
            r_lut[k] <= '0;
         r_odo <= '0;
         r_vld <= 1'b0;
         r_rdy <= 1'b0;
      end else if (enb) begin
         if (lut_ld_wrn) begin
            for (int k = 0; k < c_STORE; k++)
               r_lut[k] <= w_sum[k];
            r_rdy <= 1'b1;
            r_vld <= 1'b0;
         end else begin
            r_odo <= w_rd;
            r_vld <= r_rdy;
         end
      end
   end

   assign lut_odo     = r_odo;
   assign lut_odo_vld = r_vld;
   assign lut_rdy     = r_rdy;

endmodule

`default_nettype wire

// File: tb/tb_al_accel_lut.sv
// +--------------------------------------------------------------------------+
// | tb_al_accel_lut                                                          |
// | Directed self-checking bench for al_accel_lut (either table build).      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_al_accel_lut;
   import al_accel_pkg::*;

   logic          clk;
   logic          resetn;
   logic          enb;
   logic          lut_ld_wrn;
   logic [DW-1:0] lut_idi_0;
   logic [DW-1:0] lut_idi_1;
   logic [DW-1:0] lut_idi_2;
   logic          lut_wdi_sbit_0;
   logic          lut_wdi_sbit_1;
   logic          lut_wdi_sbit_2;
   logic [OW-1:0] lut_odo;
   logic          lut_odo_vld;
   logic          lut_rdy;

   int n_checks = 0;
   int n_pass   = 0;
   int cur_a0, cur_a1, cur_a2;

   al_accel_lut u_dut (
      .clk            (clk),
      .resetn         (resetn),
      .enb            (enb),
      .lut_ld_wrn     (lut_ld_wrn),
      .lut_idi_0      (lut_idi_0),
      .lut_idi_1      (lut_idi_1),
      .lut_idi_2      (lut_idi_2),
      .lut_wdi_sbit_0 (lut_wdi_sbit_0),
      .lut_wdi_sbit_1 (lut_wdi_sbit_1),
      .lut_wdi_sbit_2 (lut_wdi_sbit_2),
      .lut_odo        (lut_odo),
      .lut_odo_vld    (lut_odo_vld),
      .lut_rdy        (lut_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   function automatic int odo_val();
      logic signed [OW-1:0] v;
      v = lut_odo;
      return int'(v);
   endfunction

   function automatic int model(input int a0, input int a1, input int a2, input int s);
      return (s[0] ? -a0 : a0) + (s[1] ? -a1 : a1) + (s[2] ? -a2 : a2);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int a0, input int a1, input int a2, input int cycles);
      lut_ld_wrn = 1'b1;
      lut_idi_0  = 8'(a0);
      lut_idi_1  = 8'(a1);
      lut_idi_2  = 8'(a2);
      cur_a0 = a0; cur_a1 = a1; cur_a2 = a2;
      repeat (cycles) tick();
   endtask

   task automatic do_read(input int s, input string tag, input int exp);
      lut_ld_wrn     = 1'b0;
      lut_wdi_sbit_0 = s[0];
      lut_wdi_sbit_1 = s[1];
      lut_wdi_sbit_2 = s[2];
      tick();
      check(tag, odo_val(), exp);
      check({tag, "_vld"}, int'(lut_odo_vld), 1);
   endtask

   initial begin
      resetn = 1'b0; enb = 1'b0; lut_ld_wrn = 1'b0;
      lut_idi_0 = '0; lut_idi_1 = '0; lut_idi_2 = '0;
      lut_wdi_sbit_0 = 1'b0; lut_wdi_sbit_1 = 1'b0; lut_wdi_sbit_2 = 1'b0;
      cur_a0 = 0; cur_a1 = 0; cur_a2 = 0;
      #23;
      check("rst_odo", odo_val(), 0);
      check("rst_vld", int'(lut_odo_vld), 0);
      check("rst_rdy", int'(lut_rdy), 0);
      resetn = 1'b1;
      enb    = 1'b1;
      tick();

      // Read before any load
      tick();
      check("preload_odo", odo_val(), 0);
      check("preload_vld", int'(lut_odo_vld), 0);
      check("preload_rdy", int'(lut_rdy), 0);

      do_load(-10, 64, -85, 1);
      check("ld_rdy", int'(lut_rdy), 1);
      check("ld_vld", int'(lut_odo_vld), 0);
      check("ld_odo_hold", odo_val(), 0);
      do_read(3'b000, "r000", -31);
      do_read(3'b111, "r111", 31);
      do_read(3'b001, "r001", -11);
      do_read(3'b010, "r010", -159);
      do_read(3'b100, "r100", 139);
      do_read(3'b011, "r011", -139);
      do_read(3'b101, "r101", 159);
      do_read(3'b110, "r110", 11);

      // Extremes
      do_load(-128, -128, -128, 1);
      do_read(3'b111, "min_r111", 384);
      do_read(3'b000, "min_r000", -384);
      do_load(127, 127, 127, 1);
      do_read(3'b000, "max_r000", 381);
      do_read(3'b111, "max_r111", -381);

      // Stall: neither a pending load nor a read may take effect
      enb = 1'b0;
      lut_ld_wrn = 1'b1;
      lut_idi_0 = 8'd1; lut_idi_1 = 8'd2; lut_idi_2 = 8'd3;
      tick();
      lut_ld_wrn = 1'b0;
      lut_wdi_sbit_0 = 1'b0; lut_wdi_sbit_1 = 1'b0; lut_wdi_sbit_2 = 1'b0;
      tick();
      check("stall_odo", odo_val(), -381);
      check("stall_vld", int'(lut_odo_vld), 1);
      check("stall_rdy", int'(lut_rdy), 1);
      enb = 1'b1;
      do_read(3'b000, "resume_r000", 381);
      do_read(3'b001, "resume_r001", 127);

      // Alternating load / read, two cycles each
      do_load(1, 2, 3, 2);
      check("reld1_vld", int'(lut_odo_vld), 0);
      check("reld1_odo_hold", odo_val(), 127);
      do_read(3'b000, "reld1_r000", 6);
      do_read(3'b111, "reld1_r111", -6);
      do_load(5, -7, 100, 2);
      do_read(3'b010, "reld2_r010", 112);
      do_read(3'b101, "reld2_r101", -112);

      // Asynchronous reset mid-stream
      #2;
      resetn = 1'b0;
      #1;
      check("arst_rdy", int'(lut_rdy), 0);
      check("arst_odo", odo_val(), 0);
      check("arst_vld", int'(lut_odo_vld), 0);
      #1;
      resetn = 1'b1;
      lut_ld_wrn = 1'b0;
      lut_wdi_sbit_0 = 1'b1; lut_wdi_sbit_1 = 1'b1; lut_wdi_sbit_2 = 1'b1;
      tick();
      check("post_rst_odo", odo_val(), 0);
      check("post_rst_vld", int'(lut_odo_vld), 0);

      // Random loads, all eight sign patterns each
      for (int n = 0; n < 4; n++) begin
         do_load(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                 int'($urandom_range(255)) - 128, 1);
         for (int s = 0; s < 8; s++)
            do_read(s, $sformatf("rnd%0d_s%0d", n, s), model(cur_a0, cur_a1, cur_a2, s));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/al_accel_lut.md
Name: al_accel_lut

Overview:
- 3-lane lookup-table engine for binary-weight (sign-only) dot products in the ML accelerator datapath.
- Load phase: the block captures the three signed 8-bit activations and precomputes all 8 signed sums ±a0 ±a1 ±a2.
- Read phase: the three weight sign bits index that table, so one partial dot product is produced per cycle.

Parameters:
- DW, 8, activation width (signed two's complement).
- OW, DW+2 (10), output width; holds the range -384..+384 without overflow.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- enb  in  1  clock enable; when 0, all state holds
- lut_ld_wrn  in  1  1 = load table from lut_idi_*; 0 = read table with lut_wdi_sbit_*
- lut_idi_0  in  DW  signed activation, lane 0
- lut_idi_1  in  DW  signed activation, lane 1
- lut_idi_2  in  DW  signed activation, lane 2
- lut_wdi_sbit_0  in  1  weight sign, lane 0 (1 = negative)
- lut_wdi_sbit_1  in  1  weight sign, lane 1
- lut_wdi_sbit_2  in  1  weight sign, lane 2
- lut_odo  out  OW  signed looked-up sum, registered
- lut_odo_vld  out  1  lut_odo updated this cycle
- lut_rdy  out  1  table holds valid data

Behaviour:
- Reset (resetn=0, asynchronous):
  - all 8 table entries = 0
  - lut_odo = 0, lut_odo_vld = 0, lut_rdy = 0
- Table definition: entry[k], k = {s2,s1,s0}, equals sum over lanes i of (k[i] ? -sext(idi_i) : +sext(idi_i)).
  - Computed in OW bits; -(-128) = +128 is exact, with no saturation or wrap.
- Load (enb=1, lut_ld_wrn=1) at a rising clk:
  - all 8 entries written in one cycle; lut_rdy <= 1
  - lut_odo holds its value; lut_odo_vld <= 0
  - Back-to-back load cycles overwrite the table each cycle.
- Read (enb=1, lut_ld_wrn=0) at a rising clk:
  - lut_odo <= entry[{lut_wdi_sbit_2, lut_wdi_sbit_1, lut_wdi_sbit_0}]
  - lut_odo_vld <= lut_rdy
  - Latency 1 cycle. Consecutive reads give one result per cycle.
  - Reading before any load returns 0 with lut_odo_vld = 0.
- Load and read are mutually exclusive per cycle, selected by lut_ld_wrn. A read immediately after a load sees the new table.
- enb=0: table, lut_odo, lut_odo_vld and lut_rdy all hold.
  - lut_odo_vld is not cleared, so a stalled valid result stays presented.
- Reset mid-operation clears the table and lut_rdy immediately; the next load is required before valid reads.
- Symmetry: entry[~k] = -entry[k] for all k.

Optional Feature:
- AL_ACCEL_LUT_SYM_EN defined:
  - only entries k=0..3 (s2=0) are stored.
  - For s2=1, the output is the two's-complement negation of entry[~k & 3].
  - Less storage; externally cycle-identical to full mode.
- Undefined: all 8 entries are stored explicitly. The bench must pass unchanged in both builds.

Decomposition:
- Package al_accel_pkg:
  - DW, OW, LUT_DEPTH=8
  - typedef of the signed OW-bit LUT word
  - function sext_dw_to_ow
- Sub-module al_accel_lut_sum: combinational signed 3-input add.
  - Inputs: three DW activations and a 3-bit sign pattern.
  - Output: the OW-bit sum.
  - Instantiated 8 times (4 under AL_ACCEL_LUT_SYM_EN) in the load path.

Test Plan:
- Reset and pre-load read: reset, then read with sbits 000 -> lut_odo=0, lut_odo_vld=0, lut_rdy=0.
- Load idi = -10, 64, -85 for one cycle, then read:
  - sbits 000 -> -31
  - sbits 111 -> +31
  - sbits 001 -> -11
  - sbits 010 -> -159
  - sbits 100 -> +139
  - each with lut_odo_vld=1 one cycle after the read
- Extremes:
  - load -128, -128, -128, read 111 -> +384; read 000 -> -384
  - load 127, 127, 127, read 000 -> +381
- enb gating: drop enb mid-read with new sbits and different idi -> lut_odo, lut_odo_vld and the table are unchanged; raising enb resumes one result per cycle.
- Reload and reset:
  - alternate load (20 ns) / read (20 ns) twice with new idi -> the read right after the second load reflects the new table.
  - assert resetn mid-stream -> lut_rdy and lut_odo clear immediately.
- Build both with and without AL_ACCEL_LUT_SYM_EN and compare all 8 sign patterns for random loads -> identical lut_odo sequences.
